// File: rtl/pci_arb_pkg.sv
// Shared types and widths for the PCI read-back register arbiter.
package pci_arb_pkg;

   localparam int NUM_REQ_MAX = 8;
   localparam int DATA_W      = 32;
   localparam int SRC_W       = 3;
   localparam int DROP_W      = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_RD,
      DONE
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or
// after the pointer, wrapping modulo NUM_REQ.
module rr_pick
   import pci_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [SRC_W-1:0]   grant,
   output logic               found
);

   int idx;

   // Scan from the farthest candidate back toward the pointer so the closest hit wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (((req >> idx) & NUM_REQ'(1)) != '0) begin
            grant = SRC_W'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pci_rd_arbiter.sv
// Round-robin arbiter sharing the single 32-bit PCI target read-back register
// between internal status producers. One word is loaded and held until the
// host completes a read data phase, then the register passes to the next
// requester in rotation.
// Optional feature macro: PCI_RD_TIMEOUT_EN (host-read timeout with drop counter).
module pci_rd_arbiter
   import pci_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [NUM_REQ-1:0]        REQ,
   input  logic [DATA_W*NUM_REQ-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]        ACK,
   output logic [DATA_W-1:0]         RD_DATA,
   output logic [SRC_W-1:0]          RD_SRC,
   output logic                      RD_VALID,
   input  logic                      HOST_RD,
   output logic [DROP_W-1:0]         DROP_CNT
);

   arb_state_t          state;
   logic [SRC_W-1:0]    ptr;
   logic [SRC_W-1:0]    grant_idx;
   logic [SRC_W-1:0]    pick_idx;
   logic                pick_found;
   logic [DATA_W-1:0]   sel_word;
   logic [NUM_REQ-1:0]  ack_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic [SRC_W-1:0]    rd_src_q;
   logic                rd_valid_q;
   logic                timeout_hit;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req   (REQ),
      .ptr   (ptr),
      .grant (pick_idx),
      .found (pick_found)
   );

   // Word of the registered grant, taken from the flat requester data bus.
   always_comb begin
      sel_word = DATA_W'(REQ_DATA >> (int'(grant_idx) * DATA_W));
   end

`ifdef PCI_RD_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0]       wait_cnt;
   logic [DROP_W-1:0] drop_q;

   assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
   assign DROP_CNT    = drop_q;
`else
   assign timeout_hit = 1'b0;
   assign DROP_CNT    = '0;
`endif

   // Arbitration FSM; every output comes straight from a register here.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state      <= IDLE;
         ptr        <= '0;
         grant_idx  <= '0;
         ack_q      <= '0;
         rd_data_q  <= '0;
         rd_src_q   <= '0;
         rd_valid_q <= 1'b0;
`ifdef PCI_RD_TIMEOUT_EN
         wait_cnt   <= '0;
         drop_q     <= '0;
`endif
      end else begin
         ack_q <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_idx <= pick_idx;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               rd_data_q  <= sel_word;
               rd_src_q   <= grant_idx;
               ack_q      <= NUM_REQ'(1) << grant_idx;
               rd_valid_q <= 1'b1;
               state      <= WAIT_RD;
`ifdef PCI_RD_TIMEOUT_EN
               wait_cnt   <= '0;
`endif
            end
            WAIT_RD: begin
               if (HOST_RD) begin
                  state <= DONE;
               end else if (timeout_hit) begin
                  state <= DONE;
`ifdef PCI_RD_TIMEOUT_EN
                  if (drop_q != '1) begin
                     drop_q <= drop_q + DROP_W'(1);
                  end
`endif
               end else begin
`ifdef PCI_RD_TIMEOUT_EN
                  wait_cnt <= wait_cnt + 16'd1;
`endif
               end
            end
            DONE: begin
               rd_valid_q <= 1'b0;
               if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
                  ptr <= '0;
               end else begin
                  ptr <= grant_idx + SRC_W'(1);
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign ACK      = ack_q;
   assign RD_DATA  = rd_data_q;
   assign RD_SRC   = rd_src_q;
   assign RD_VALID = rd_valid_q;

endmodule

// File: doc/pci_rd_arbiter.md
# pci_rd_arbiter

Round-robin arbiter that shares the single 32-bit PCI target read-back register between several internal status producers (axis counters, limit-switch latches, FIFO levels). It sits between the internal requesters and the PCI target. It loads one requester's word at a time into the read register and holds it until the host completes a read data phase. It then releases the register to the next requester.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1024: host-read wait limit in CLK cycles, 2..65535; used only with the timeout feature.
- `CLK`  in  1  PCI clock; all logic on rising edge.
- `RST_N`  in  1  reset, synchronous, active-low.
- `REQ`  in  NUM_REQ  per-requester request; level, held until ACK.
- `REQ_DATA`  in  32*NUM_REQ  requester word; requester i drives bits [32i+31:32i]; stable while REQ[i]=1.
- `ACK`  out  NUM_REQ  one-cycle pulse when requester i's word is captured.
- `RD_DATA`  out  32  word presented to the PCI target read path.
- `RD_SRC`  out  3  index of the requester whose word is in RD_DATA.
- `RD_VALID`  out  1  RD_DATA holds an unread word.
- `HOST_RD`  in  1  one-cycle pulse from the target on completion of a read data phase (IRDY and TRDY both asserted, read command).
- `DROP_CNT`  out  8  saturating count of words dropped by timeout.

## Operation
- States:
  - IDLE: RD_VALID=0; wait for any REQ.
  - LOAD: capture the selected word; ACK pulse; RD_VALID rises.
  - WAIT_RD: hold RD_DATA and RD_SRC; wait for HOST_RD.
  - DONE: clear RD_VALID; advance the pointer.
- IDLE→LOAD when REQ≠0. The grant goes to the first set REQ bit at or after PTR, wrapping modulo NUM_REQ. The grant index is registered.
- LOAD→WAIT_RD unconditionally.
- WAIT_RD→DONE on HOST_RD=1.
- DONE→IDLE unconditionally. PTR becomes the grant index +1, wrapping NUM_REQ-1→0.
- HOST_RD in IDLE, LOAD or DONE is ignored and produces no state change.
- A requester that drops REQ before being granted is skipped and receives no ACK.
- A requester must drop REQ in the cycle after its ACK. A REQ still high after that is a new request, served after the other requesters in rotation.
- Reset values:
  - ACK=0, RD_DATA=0, RD_SRC=0, RD_VALID=0, DROP_CNT=0.
  - PTR=0, state IDLE.
- Reset in any state aborts the in-flight word. No ACK is issued and nothing is counted.
- RD_SRC upper bits are 0 when NUM_REQ<8.

## Timing
- REQ seen high in IDLE at edge n: state is LOAD after edge n, and RD_DATA, RD_SRC, ACK and RD_VALID are registered at edge n+1.
- HOST_RD high at edge m: RD_VALID=0 after edge m+1 (DONE). The next grant is decided at edge m+2, at the earliest.
- Minimum word-to-word period is 4 cycles plus host read latency.
- RD_DATA is unchanged from LOAD until the next LOAD, so the target may sample it at any point in its data phase.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `PCI_RD_TIMEOUT_EN` defined:
  - A 16-bit counter runs while in WAIT_RD.
  - After TIMEOUT_CYCLES cycles without HOST_RD, the state goes to DONE, the word is discarded and DROP_CNT increments, saturating at 255.
  - HOST_RD arriving in the same cycle as expiry counts as a read, not a drop.
- Undefined: WAIT_RD waits forever, no counter is built, and DROP_CNT is constant 0.

## Structure
- Package `pci_arb_pkg` holds:
  - the state enum (IDLE, LOAD, WAIT_RD, DONE);
  - NUM_REQ_MAX=8, DATA_W=32, SRC_W=3, DROP_W=8.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are the grant index and a found flag. Instantiated once.

## Test plan
- Reset release, then REQ=4'b0001 with REQ_DATA[31:0]=32'hDEADBEEF: ACK[0] pulses once, RD_DATA=32'hDEADBEEF, RD_SRC=0 and RD_VALID=1 until HOST_RD, then RD_VALID=0.
- REQ=4'b1111 held, each with a distinct word, HOST_RD issued each time RD_VALID=1: grant order 0,1,2,3,0; never the same index twice in a row.
- HOST_RD pulses while in IDLE and in LOAD: no state change, and the following word stays valid until a later HOST_RD.
- RST_N=0 for 1 cycle during WAIT_RD: all outputs return to 0, and a subsequent REQ=4'b0100 is granted to index 2 (pointer back at 0).
- With `PCI_RD_TIMEOUT_EN` and TIMEOUT_CYCLES=16, no HOST_RD: RD_VALID drops after 16 cycles and DROP_CNT=1. Repeating 300 times leaves DROP_CNT=255.
- REQ[1] asserted then dropped before its grant while REQ[2] is pending: ACK[1] never pulses and ACK[2] pulses.
